// File: rtl/dynamic_quantization_pkg.sv
// Shared definitions for the integer re-quantizer: precision codes, signed
// range limits and small width helpers.
package dynamic_quantization_pkg;

    localparam logic [15:0] PREC_32 = 16'h0001;
    localparam logic [15:0] PREC_16 = 16'h0002;
    localparam logic [15:0] PREC_8  = 16'h0004;

    localparam logic [5:0] W_INVALID = 6'd0;

    localparam logic signed [31:0] S8_MAX  = 32'sh0000_007F;
    localparam logic signed [31:0] S8_MIN  = 32'shFFFF_FF80;
    localparam logic signed [31:0] S16_MAX = 32'sh0000_7FFF;
    localparam logic signed [31:0] S16_MIN = 32'shFFFF_8000;

    // Only exact one-hot codes are legal; anything else maps to width 0.
    function automatic logic [5:0] prec_width(input logic [15:0] code);
        case (code)
            PREC_32: return 6'd32;
            PREC_16: return 6'd16;
            PREC_8:  return 6'd8;
            default: return W_INVALID;
        endcase
    endfunction

    function automatic logic [31:0] sign_extend(input logic [31:0] x, input logic [5:0] w);
        case (w)
            6'd8:    return {{24{x[7]}}, x[7:0]};
            6'd16:   return {{16{x[15]}}, x[15:0]};
            default: return x;
        endcase
    endfunction

endpackage

// File: rtl/dynamic_quantization_saturate.sv
// Combinational clamp of a signed 32-bit value into the signed range of an
// 8- or 16-bit target; 32-bit targets pass straight through.
module quant_saturate
    import dynamic_quantization_pkg::*;
(
    input  logic signed [31:0] value,
    input  logic        [5:0]  width,
    output logic        [31:0] result
);

    always_comb begin
        // NOTE: default assignment first so no path through the case leaves result unassigned (no latch).
        result = value;
        case (width)
            6'd8: begin
                if (value > S8_MAX)
                    result = S8_MAX;
                else if (value < S8_MIN)
                    result = S8_MIN;
            end
            6'd16: begin
                if (value > S16_MAX)
                    result = S16_MAX;
                else if (value < S16_MIN)
                    result = S16_MIN;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/dynamic_quantization.sv
// Registered signed re-quantizer between 32/16/8-bit precisions with
// saturating or wrapping narrowing; output always sign-extended to 32 bits.
module dynamic_quantization
    import dynamic_quantization_pkg::*;
#(
    parameter int SATURATE = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [15:0] data_in_precision,
    input  logic [15:0] data_out_precision,
    output logic [31:0] data_out
);

    logic [5:0]  w_in;
    logic [5:0]  w_out;
    logic [31:0] v_ext;
    logic [31:0] sat_value;
    logic [31:0] next_out;

    assign w_in  = prec_width(data_in_precision);
    assign w_out = prec_width(data_out_precision);
    assign v_ext = sign_extend(data_in, w_in);

    quant_saturate u_saturate (
        .value  (v_ext),
        .width  (w_out),
        .result (sat_value)
    );

    // Wrapping keeps the low W_out bits of data_in; these equal the low bits
    // of v_ext because narrowing implies W_out < W_in.
    always_comb begin
        next_out = '0;
        if (w_in == W_INVALID || w_out == W_INVALID)
            next_out = '0;
        else if (w_out >= w_in)
            next_out = v_ext;
        else if (SATURATE != 0)
            next_out = sat_value;
        else
            next_out = sign_extend(data_in, w_out);
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignment for registered state so all flops update together at the edge.
        if (rst)
            data_out <= '0;
        else
            data_out <= next_out;
    end

endmodule

// File: tb/tb_dynamic_quantization.sv
// Self-checking bench: saturating and wrapping instances checked every cycle
// against an arithmetic model, plus directed literal expectations.
module tb_dynamic_quantization;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] data_in;
    logic [15:0] data_in_precision;
    logic [15:0] data_out_precision;
    logic [31:0] out_sat;
    logic [31:0] out_wrap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dynamic_quantization #(.SATURATE(1)) dut_sat (
        .clk                (clk),
        .rst                (rst),
        .data_in            (data_in),
        .data_in_precision  (data_in_precision),
        .data_out_precision (data_out_precision),
        .data_out           (out_sat)
    );

    dynamic_quantization #(.SATURATE(0)) dut_wrap (
        .clk                (clk),
        .rst                (rst),
        .data_in            (data_in),
        .data_in_precision  (data_in_precision),
        .data_out_precision (data_out_precision),
        .data_out           (out_wrap)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    function automatic int code_width(input logic [15:0] code);
        if (code == 16'h0001) return 32;
        if (code == 16'h0002) return 16;
        if (code == 16'h0004) return 8;
        return 0;
    endfunction

    // Reference: interpret as a mathematical integer, then clamp or reduce modulo 2^W_out.
    function automatic logic [31:0] model(input logic [31:0] din, input logic [15:0] pin,
                                          input logic [15:0] pout, input bit sat);
        int     win;
        int     wout;
        longint v;
        longint hi;
        longint lo;
        longint m;
        win  = code_width(pin);
        wout = code_width(pout);
        if (win == 0 || wout == 0) return 32'h0;
        v = longint'(din) % (longint'(1) << win);
        if (v >= (longint'(1) << (win - 1))) v = v - (longint'(1) << win);
        if (wout < win) begin
            hi = (longint'(1) << (wout - 1)) - 1;
            lo = -(longint'(1) << (wout - 1));
            if (sat) begin
                if (v > hi) v = hi;
                else if (v < lo) v = lo;
            end else begin
                m = v % (longint'(1) << wout);
                if (m < 0) m = m + (longint'(1) << wout);
                if (m > hi) m = m - (longint'(1) << wout);
                v = m;
            end
        end
        return v[31:0];
    endfunction

    // Every cycle: predict from the inputs sampled at the edge, compare 1 time unit later.
    always @(posedge clk) begin
        logic [31:0] exp_sat;
        logic [31:0] exp_wrap;
        if (rst) begin
            exp_sat  = 32'h0;
            exp_wrap = 32'h0;
        end else begin
            exp_sat  = model(data_in, data_in_precision, data_out_precision, 1'b1);
            exp_wrap = model(data_in, data_in_precision, data_out_precision, 1'b0);
        end
        #1;
        check("model_sat", out_sat, exp_sat);
        check("model_wrap", out_wrap, exp_wrap);
    end

    task automatic apply(input logic [31:0] din, input logic [15:0] pin,
                         input logic [15:0] pout, input logic r);
        rst                = r;
        data_in            = din;
        data_in_precision  = pin;
        data_out_precision = pout;
        @(posedge clk);
        #2;
    endtask

    initial begin
        logic [15:0] codes [3];
        codes[0] = 16'h0001;
        codes[1] = 16'h0002;
        codes[2] = 16'h0004;

        rst                = 1'b1;
        data_in            = 32'hDEAD_BEEF;
        data_in_precision  = 16'h0001;
        data_out_precision = 16'h0001;

        apply(32'hDEAD_BEEF, 16'h0001, 16'h0001, 1'b1);
        check("reset_c1", out_sat, 32'h0);
        apply(32'hDEAD_BEEF, 16'h0001, 16'h0001, 1'b1);
        check("reset_c2", out_sat, 32'h0);
        check("reset_wrap", out_wrap, 32'h0);
        apply(32'hDEAD_BEEF, 16'h0001, 16'h0001, 1'b0);
        check("post_reset", out_sat, 32'hDEAD_BEEF);

        apply(32'h1234_5680, 16'h0004, 16'h0001, 1'b0);
        check("widen_8_32", out_sat, 32'hFFFF_FF80);
        apply(32'h0000_7FFF, 16'h0002, 16'h0002, 1'b0);
        check("equal_16", out_sat, 32'h0000_7FFF);
        apply(32'h00AB_8001, 16'h0002, 16'h0001, 1'b0);
        check("widen_16_32", out_sat, 32'hFFFF_8001);

        apply(32'h0001_0000, 16'h0001, 16'h0002, 1'b0);
        check("sat_32_16_pos", out_sat, 32'h0000_7FFF);
        check("wrap_32_16_pos", out_wrap, 32'h0000_0000);
        apply(32'h8000_0000, 16'h0001, 16'h0002, 1'b0);
        check("sat_32_16_neg", out_sat, 32'hFFFF_8000);
        apply(32'h0000_1234, 16'h0002, 16'h0004, 1'b0);
        check("sat_16_8_pos", out_sat, 32'h0000_007F);
        check("wrap_16_8_1234", out_wrap, 32'h0000_0034);
        apply(32'h0000_FF80, 16'h0002, 16'h0004, 1'b0);
        check("sat_16_8_min", out_sat, 32'hFFFF_FF80);
        apply(32'h0000_00F0, 16'h0002, 16'h0004, 1'b0);
        check("sat_16_8_f0", out_sat, 32'h0000_007F);
        check("wrap_16_8_f0", out_wrap, 32'hFFFF_FFF0);

        apply(32'h0000_007F, 16'h0001, 16'h0004, 1'b0);
        check("bound_8_max", out_sat, 32'h0000_007F);
        apply(32'hFFFF_FF80, 16'h0001, 16'h0004, 1'b0);
        check("bound_8_min", out_sat, 32'hFFFF_FF80);
        apply(32'h0000_7FFF, 16'h0001, 16'h0002, 1'b0);
        check("bound_16_max", out_sat, 32'h0000_7FFF);
        apply(32'hFFFF_8000, 16'h0001, 16'h0002, 1'b0);
        check("bound_16_min", out_sat, 32'hFFFF_8000);
        apply(32'h8000_0000, 16'h0001, 16'h0004, 1'b0);
        check("sat_32_8_min", out_sat, 32'hFFFF_FF80);
        check("wrap_32_8_min", out_wrap, 32'h0000_0000);

        apply(32'h5555_5555, 16'h0003, 16'h0001, 1'b0);
        check("inv_multihot", out_sat, 32'h0);
        apply(32'h5555_5555, 16'h0001, 16'h0000, 1'b0);
        check("inv_out_zero", out_sat, 32'h0);
        apply(32'h5555_5555, 16'h0008, 16'h0001, 1'b0);
        check("inv_in_high", out_wrap, 32'h0);

        for (int i = 0; i < 100; i++) begin
            apply($urandom, codes[$urandom_range(0, 2)], codes[$urandom_range(0, 2)], 1'b0);
        end

        apply(32'hCAFE_F00D, 16'h0001, 16'h0001, 1'b1);
        check("reset_again", out_sat, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
